// File: rtl/ryuki_datatypes.sv
// Shared types and constants for the data-memory responder slice.
package ryuki_datatypes;

  typedef enum logic [1:0] {
    READY    = 2'b00,
    WAIT_LAT = 2'b01,
    RESP     = 2'b10
  } mem_resp_state_t;

  // Byte-address bits below the word index.
  localparam int unsigned WORD_OFFSET = 2;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port RAM with per-byte write enables and a registered read port.
module dmem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH),
  localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [BE_W-1:0]       be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read register holds its value between read strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: grant, fixed-latency rvalid pulse, byte-enabled RAM.
// Define GNT_STALL_EN to insert LFSR-driven pseudo-random grant stalls in READY.
module data_mem_responder
  import ryuki_datatypes::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  mem_resp_state_t       state_q;
  logic [3:0]            cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  we_q;
  logic [BE_W-1:0]       be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rvalid_q;

  logic                  fire;
  logic [IDX_W-1:0]      acc_idx;
  logic                  acc_we;
  logic [BE_W-1:0]       acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;

`ifdef GNT_STALL_EN
  logic [15:0] lfsr_q;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign gnt_o = (state_q == READY) & req_i & ~lfsr_q[0];
`else
  assign gnt_o = (state_q == READY) & req_i;
`endif

  // fire marks the edge entering RESP; in READY the live request is used since the
  // capture registers only load on that same edge.
  always_comb begin
    fire = 1'b0;
    if (state_q == READY) begin
      fire      = gnt_o && (RESP_LATENCY == 1);
      acc_idx   = addr_i[WORD_OFFSET +: IDX_W];
      acc_we    = we_i;
      acc_be    = be_i;
      acc_wdata = wdata_i;
    end else begin
      fire      = (state_q == WAIT_LAT) && (cnt_q == 4'd1);
      acc_idx   = idx_q;
      acc_we    = we_q;
      acc_be    = be_q;
      acc_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= READY;
      cnt_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        READY: begin
          if (gnt_o) begin
            idx_q   <= addr_i[WORD_OFFSET +: IDX_W];
            we_q    <= we_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            if (RESP_LATENCY == 1) begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
            end else begin
              state_q <= WAIT_LAT;
              cnt_q   <= 4'(RESP_LATENCY - 1);
            end
          end
        end
        WAIT_LAT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
          end
        end
        RESP: begin
          state_q <= READY;
        end
        default: begin
          state_q <= READY;
        end
      endcase
    end
  end

  assign rvalid_o = rvalid_q;

  // Strobes are blocked during reset so an abandoned write never reaches the array.
  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_dmem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (fire & acc_we & ~rst),
    .re    (fire & ~acc_we & ~rst),
    .be    (acc_be),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (rdata_o)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (latency 1 and 3) with directed transactions.
module tb_data_mem_responder;

`ifdef GNT_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  localparam int LAT [2] = '{1, 3};

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, we, gnt, rvalid;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0]  be;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]      q0[$];
  logic [31:0]      q1[$];
  logic [1:0][31:0] last_rd;
  int               mcnt [2];
  logic [15:0]      mlfsr;

  data_mem_responder #(.RESP_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0])
  );

  data_mem_responder #(.RESP_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic bit exp_gnt(input int d);
    return (mcnt[d] == 0) && req[d] && !(STALL && mlfsr[0]);
  endfunction

  function automatic void push_exp(input int d, input logic [31:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  // Reference timing model: mcnt counts down from LAT after a grant; rvalid when it is 1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt[0] <= 0;
      mcnt[1] <= 0;
      mlfsr   <= 16'hACE1;
    end else begin
      mlfsr <= {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
      for (int d = 0; d < 2; d++) begin
        if (mcnt[d] != 0)    mcnt[d] <= mcnt[d] - 1;
        else if (exp_gnt(d)) mcnt[d] <= LAT[d];
      end
    end
  end

  // Monitor: cycle-accurate gnt/rvalid, and rdata popped from the scoreboard on rvalid.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] e;
        bit          have;
        check($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(exp_gnt(d)));
        check($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(mcnt[d] == 1));
        if (rvalid[d]) begin
          have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!have) begin
            check($sformatf("rvalid%0d_unexpected", d), 32'd1, 32'd0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rdata%0d", d), rdata[d], e);
          end
        end
      end
    end
  end

  task automatic wait_idle(input int d);
    bit idle = 1'b0;
    for (int n = 0; n < 64 && !idle; n++) begin
      @(negedge clk);
      if (mcnt[d] == 0) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    bit granted = 1'b0;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    for (int n = 0; n < 64 && !granted; n++) begin
      @(negedge clk);
      if (gnt[d]) begin
        granted = 1'b1;
        if (w) begin
          push_exp(d, last_rd[d]);
        end else begin
          push_exp(d, exp_rd);
          last_rd[d] = exp_rd;
        end
      end
      @(posedge clk); #1;
    end
    req[d] = 1'b0;
    if (!granted) check("gnt_timeout", 32'd0, 32'd1);
    wait_idle(d);
  endtask

  task automatic flush_after_reset();
    q0.delete();
    q1.delete();
    last_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  gcyc[$];
    int  vcyc[$];
    bit  granted;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0; last_rd = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid0", 32'(rvalid[0]), 32'd0);
    check("reset_rdata0", rdata[0], 32'd0);
    check("reset_rvalid1", 32'(rvalid[1]), 32'd0);
    rst = 1'b0;

    // Latency 1: write/read, byte enables, zero byte enable, aliasing.
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 32'h0);
    txn(0, 1'b1, 32'h20, 4'b0101, 32'h11223344, 32'h0);
    txn(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'hFF22FF44);
    txn(0, 1'b1, 32'h20, 4'h0, 32'h00000000, 32'h0);
    txn(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'hFF22FF44);
    txn(0, 1'b1, 32'h4, 4'hF, 32'hA5A5A5A5, 32'h0);
    txn(0, 1'b0, 32'h1004, 4'h0, 32'h0, 32'hA5A5A5A5);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF);

    // Asynchronous reset during a response cycle with req held high.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20;
    granted = 1'b0;
    for (int n = 0; n < 64 && !granted; n++) begin
      @(negedge clk);
      if (gnt[0]) begin
        granted = 1'b1;
        push_exp(0, 32'hFF22FF44);
      end
      @(posedge clk); #1;
    end
    check("rst_pre_rvalid", 32'(rvalid[0]), 32'd1);
    check("rst_pre_rdata", rdata[0], 32'hFF22FF44);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rvalid", 32'(rvalid[0]), 32'd0);
    check("rst_async_rdata", rdata[0], 32'd0);
    check("rst_async_gnt", 32'(gnt[0]), STALL ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst = 1'b0;
    flush_after_reset();

    // Latency 3: continuous requests.
    txn(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt[1]) begin
        gcyc.push_back(i);
        push_exp(1, 32'hDEADBEEF);
        last_rd[1] = 32'hDEADBEEF;
      end
      if (rvalid[1]) vcyc.push_back(i);
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    if (!STALL) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("lat3_gnt_cycle%0d", k), (gcyc.size() > k) ? gcyc[k] : -1, 4 * k);
        check($sformatf("lat3_rvalid_cycle%0d", k), (vcyc.size() > k) ? vcyc[k] : -1, 4 * k + 3);
      end
      check("lat3_gnt_count", gcyc.size(), 3);
    end
    wait_idle(1);

    // Reset between a write grant and its rvalid: the write must be lost.
    txn(1, 1'b1, 32'h30, 4'hF, 32'h12345678, 32'h0);
    txn(1, 1'b0, 32'h30, 4'h0, 32'h0, 32'h12345678);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; be[1] = 4'hF; wdata[1] = 32'hBAD0BAD0;
    granted = 1'b0;
    for (int n = 0; n < 64 && !granted; n++) begin
      @(negedge clk);
      if (gnt[1]) granted = 1'b1;
      @(posedge clk); #1;
    end
    if (!granted) check("abort_gnt_timeout", 32'd0, 32'd1);
    req[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_rvalid", 32'(rvalid[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    flush_after_reset();
    txn(1, 1'b0, 32'h30, 4'h0, 32'h0, 32'h12345678);
    txn(0, 1'b0, 32'h1004, 4'h0, 32'h0, 32'hA5A5A5A5);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
